// File: rtl/exp_pkg.sv
// ---------------------------------------------------------------------------
// exp_pkg
// Shared helpers for the exponent-compare pipeline:
//   stage_count(lanes)   - number of pairwise-max levels needed to reduce
//                          'lanes' operands to one (ceil(log2(lanes)))
//   lane_lo(idx, width)  - low bit index of lane 'idx' in a packed vector
//                          of 'width'-bit lanes (use as vec[lane_lo(..) +: width])
// ---------------------------------------------------------------------------
package exp_pkg;

    // Number of binary-tree levels needed to reduce 'lanes' inputs to one.
    function automatic int stage_count(input int lanes);
        int levels;
        levels = 0;
        while ((1 << levels) < lanes) begin
            levels = levels + 1;
        end
        return levels;
    endfunction

    // Low bit position of a lane inside a packed multi-lane vector.
    function automatic int lane_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/exp_max_stage.sv
// ---------------------------------------------------------------------------
// exp_max_stage
// One registered level of the max tree: reduces N_IN candidate maxima to
// N_IN/2 by pairwise compare, and carries the untouched raw lane exponents
// and a valid bit so the final subtract sees data from the same beat.
//
// Parameters: WIDTH (exponent bits), N_IN (candidates in), LANES (raw lanes)
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   en          - advance enable (low while the pipeline is stalled)
//   in_valid    - valid bit of the incoming level
//   in_max      - N_IN packed candidates
//   in_raw      - LANES packed raw exponents of the beat
//   out_valid   - registered valid bit
//   out_max     - N_IN/2 packed registered maxima
//   out_raw     - registered copy of in_raw
// ---------------------------------------------------------------------------
module exp_max_stage
    import exp_pkg::*;
#(
    parameter int WIDTH = 11,
    parameter int N_IN  = 16,
    parameter int LANES = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         in_valid,
    input  logic [N_IN*WIDTH-1:0]        in_max,
    input  logic [LANES*WIDTH-1:0]       in_raw,
    output logic                         out_valid,
    output logic [(N_IN/2)*WIDTH-1:0]    out_max,
    output logic [LANES*WIDTH-1:0]       out_raw
);

    localparam int N_OUT = N_IN / 2;

    logic [N_OUT*WIDTH-1:0] max_next;
    logic [WIDTH-1:0]       left;
    logic [WIDTH-1:0]       right;

    // Pairwise max; on a tie the left (lower-index) operand wins, which only
    // matters for which lane's value is forwarded, not for the value itself.
    always_comb begin
        max_next = '0;
        left     = '0;
        right    = '0;
        for (int i = 0; i < N_OUT; i++) begin
            left  = in_max[lane_lo(2*i, WIDTH) +: WIDTH];
            right = in_max[lane_lo(2*i+1, WIDTH) +: WIDTH];
            max_next[lane_lo(i, WIDTH) +: WIDTH] = (right > left) ? right : left;
        end
    end

    // Level register: everything moves together only when the pipe advances,
    // so a stall freezes valid, maxima and raw exponents as one beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_max   <= '0;
            out_raw   <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            out_max   <= max_next;
            out_raw   <= in_raw;
        end
    end

endmodule

// File: rtl/exp_compare_pipe.sv
// ---------------------------------------------------------------------------
// exp_compare_pipe
// Pipelined block-exponent compare: finds the unsigned maximum exponent over
// LANES lanes and each lane's shift distance (max - exp_i). A balanced tree of
// log2(LANES) registered max levels is followed by one registered subtract
// level, giving a latency of log2(LANES)+1 cycles at one beat per cycle.
//
// Parameters: WIDTH (exponent bits), LANES (power of two, 2..64),
//             SHIFT_W (shift output bits, 1..WIDTH)
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset
//   in_valid     - input beat presented
//   in_ready     - beat accepted this cycle (low only while stalled)
//   in_exp       - LANES packed unsigned exponents, lane i at [i*WIDTH +: WIDTH]
//   out_valid    - result presented
//   out_ready    - downstream accepts the result
//   out_exp_max  - maximum exponent of the beat
//   out_shift    - LANES packed shifts, lane i at [i*SHIFT_W +: SHIFT_W]
//
// Build option: EXP_COMPARE_PIPE_SAT_EN - when defined, a shift larger than
// 2^SHIFT_W-1 saturates to all ones; otherwise its low SHIFT_W bits are kept.
// ---------------------------------------------------------------------------
module exp_compare_pipe
    import exp_pkg::*;
#(
    parameter int WIDTH   = 11,
    parameter int LANES   = 16,
    parameter int SHIFT_W = 11
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*WIDTH-1:0]     in_exp,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_exp_max,
    output logic [LANES*SHIFT_W-1:0]   out_shift
);

    localparam int L = stage_count(LANES);
    localparam logic [WIDTH:0] SHIFT_MAX = (WIDTH+1)'((1 << SHIFT_W) - 1);

    logic                     stall;
    logic                     tree_valid;
    logic [WIDTH-1:0]         tree_max;
    logic [LANES*WIDTH-1:0]   tree_raw;
    logic [LANES*SHIFT_W-1:0] shift_next;
    logic [WIDTH-1:0]         diff;

    // A held result blocks the whole pipe; reset forces ready high so the
    // upstream never sees backpressure from state that is being cleared.
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall | ~rst_n;

    // Max tree: level k reduces LANES>>k candidates to half as many, each
    // level picking up the previous level's registers.
    for (genvar k = 0; k < L; k++) begin : g_lvl
        localparam int N_IN = LANES >> k;

        logic                         valid_in;
        logic [N_IN*WIDTH-1:0]        max_in;
        logic [LANES*WIDTH-1:0]       raw_in;
        logic                         valid_q;
        logic [(N_IN/2)*WIDTH-1:0]    max_q;
        logic [LANES*WIDTH-1:0]       raw_q;

        if (k == 0) begin : g_first
            assign valid_in = in_valid;
            assign max_in   = in_exp;
            assign raw_in   = in_exp;
        end else begin : g_next
            assign valid_in = g_lvl[k-1].valid_q;
            assign max_in   = g_lvl[k-1].max_q;
            assign raw_in   = g_lvl[k-1].raw_q;
        end

        exp_max_stage #(
            .WIDTH (WIDTH),
            .N_IN  (N_IN),
            .LANES (LANES)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (~stall),
            .in_valid  (valid_in),
            .in_max    (max_in),
            .in_raw    (raw_in),
            .out_valid (valid_q),
            .out_max   (max_q),
            .out_raw   (raw_q)
        );
    end

    assign tree_valid = g_lvl[L-1].valid_q;
    assign tree_max   = g_lvl[L-1].max_q;
    assign tree_raw   = g_lvl[L-1].raw_q;

    // Per-lane shift distance. The difference is never negative because the
    // maximum was taken over these very lanes; only the narrowing differs
    // between the saturating and truncating builds.
    always_comb begin
        shift_next = '0;
        diff       = '0;
        for (int i = 0; i < LANES; i++) begin
            diff = tree_max - tree_raw[lane_lo(i, WIDTH) +: WIDTH];
`ifdef EXP_COMPARE_PIPE_SAT_EN
            if ({1'b0, diff} > SHIFT_MAX) begin
                shift_next[lane_lo(i, SHIFT_W) +: SHIFT_W] = {SHIFT_W{1'b1}};
            end else begin
                shift_next[lane_lo(i, SHIFT_W) +: SHIFT_W] = diff[SHIFT_W-1:0];
            end
`else
            shift_next[lane_lo(i, SHIFT_W) +: SHIFT_W] = diff[SHIFT_W-1:0];
`endif
        end
    end

    // Output register: holds the presented result until it is consumed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_exp_max <= '0;
            out_shift   <= '0;
        end else if (!stall) begin
            out_valid   <= tree_valid;
            out_exp_max <= tree_max;
            out_shift   <= shift_next;
        end
    end

endmodule

// File: tb/tb_exp_compare_pipe.sv
// ---------------------------------------------------------------------------
// tb_exp_compare_pipe
// Directed and scoreboard checks of exp_compare_pipe at LANES=16 (full and
// 4-bit shift widths), LANES=2 and LANES=64.
// ---------------------------------------------------------------------------
module tb_exp_compare_pipe;

    logic clk = 1'b0;
    logic rst_n;

    // Clock generation: 10-unit period.
    always #5 clk = ~clk;

    int vec_count;
    int miss_count;

    logic         in_valid;
    logic [175:0] in_exp;
    logic         out_ready;

    logic         d16_in_ready, d16_out_valid;
    logic [10:0]  d16_out_exp_max;
    logic [175:0] d16_out_shift;

    logic         sat_in_ready, sat_out_valid;
    logic [10:0]  sat_out_exp_max;
    logic [63:0]  sat_out_shift;

    logic         r2_in_valid, r2_in_ready, r2_out_valid, r2_out_ready;
    logic [21:0]  r2_in_exp, r2_out_shift;
    logic [10:0]  r2_out_exp_max;

    logic         r64_in_valid, r64_in_ready, r64_out_valid, r64_out_ready;
    logic [703:0] r64_in_exp, r64_out_shift;
    logic [10:0]  r64_out_exp_max;

    exp_compare_pipe #(.WIDTH(11), .LANES(16), .SHIFT_W(11)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d16_in_ready),
        .in_exp(in_exp), .out_valid(d16_out_valid), .out_ready(out_ready),
        .out_exp_max(d16_out_exp_max), .out_shift(d16_out_shift));

    exp_compare_pipe #(.WIDTH(11), .LANES(16), .SHIFT_W(4)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(sat_in_ready),
        .in_exp(in_exp), .out_valid(sat_out_valid), .out_ready(out_ready),
        .out_exp_max(sat_out_exp_max), .out_shift(sat_out_shift));

    exp_compare_pipe #(.WIDTH(11), .LANES(2), .SHIFT_W(11)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(r2_in_valid), .in_ready(r2_in_ready),
        .in_exp(r2_in_exp), .out_valid(r2_out_valid), .out_ready(r2_out_ready),
        .out_exp_max(r2_out_exp_max), .out_shift(r2_out_shift));

    exp_compare_pipe #(.WIDTH(11), .LANES(64), .SHIFT_W(11)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(r64_in_valid), .in_ready(r64_in_ready),
        .in_exp(r64_in_exp), .out_valid(r64_out_valid), .out_ready(r64_out_ready),
        .out_exp_max(r64_out_exp_max), .out_shift(r64_out_shift));

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [703:0] got,
                               input logic [703:0] want);
        vec_count++;
        if (got !== want) begin
            miss_count++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, want);
        end
    endtask

    // Reference model: plain max over the lanes and max-minus-lane shifts.
    function automatic void modelBeat(input logic [703:0] v, input int lanes,
                                      output logic [10:0] mx,
                                      output logic [703:0] sh);
        mx = '0;
        sh = '0;
        for (int j = 0; j < lanes; j++)
            if (v[j*11 +: 11] > mx) mx = v[j*11 +: 11];
        for (int j = 0; j < lanes; j++)
            sh[j*11 +: 11] = mx - v[j*11 +: 11];
    endfunction

    function automatic logic [175:0] makeBeat(input int b);
        logic [175:0] v;
        for (int j = 0; j < 16; j++)
            v[j*11 +: 11] = 11'((b * 97 + j * 31 + b * j * 7) % 2048);
        return v;
    endfunction

    // One isolated beat into both 16-lane instances, checked on arrival.
    task automatic applyStimulus(input string tag, input logic [175:0] v,
                                 input logic [10:0] e_max,
                                 input logic [175:0] e_sh,
                                 input logic [63:0] e_sh4);
        int lat;
        @(negedge clk);
        in_valid = 1'b1;
        in_exp   = v;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!d16_out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, "_valid"}, 704'(d16_out_valid), 704'(1));
        checkOutput({tag, "_latency"}, 704'(lat), 704'(5));
        checkOutput({tag, "_max"}, 704'(d16_out_exp_max), 704'(e_max));
        checkOutput({tag, "_shift"}, 704'(d16_out_shift), 704'(e_sh));
        checkOutput({tag, "_sat_valid"}, 704'(sat_out_valid), 704'(1));
        checkOutput({tag, "_sat_max"}, 704'(sat_out_exp_max), 704'(e_max));
        checkOutput({tag, "_sat_shift"}, 704'(sat_out_shift), 704'(e_sh4));
    endtask

    // Random traffic with random backpressure against a FIFO scoreboard.
    task automatic runRandom2(input int cycles);
        logic [21:0]  q[$];
        logic [21:0]  v;
        logic [10:0]  mx;
        logic [703:0] sh;
        for (int t = 0; t < cycles; t++) begin
            @(negedge clk);
            r2_out_ready = ($urandom_range(0, 3) != 0);
            r2_in_valid  = 1'b1;
            for (int j = 0; j < 2; j++)
                v[j*11 +: 11] = 11'($urandom_range(0, (t % 3 == 0) ? 3 : 2047));
            r2_in_exp = v;
            #1;
            if (r2_out_ready) checkOutput("r2_in_ready", 704'(r2_in_ready), 704'(1));
            if (t > 4) checkOutput("r2_full", 704'(r2_out_valid), 704'(1));
            if (r2_in_valid && r2_in_ready) q.push_back(r2_in_exp);
            if (r2_out_valid && r2_out_ready) begin
                if (q.size() == 0) begin
                    checkOutput("r2_extra", 704'(1), 704'(0));
                end else begin
                    modelBeat(704'(q.pop_front()), 2, mx, sh);
                    checkOutput("r2_max", 704'(r2_out_exp_max), 704'(mx));
                    checkOutput("r2_shift", 704'(r2_out_shift), sh);
                end
            end
        end
        @(negedge clk);
        r2_in_valid = 1'b0;
    endtask

    task automatic runRandom64(input int cycles);
        logic [703:0] q[$];
        logic [703:0] v;
        logic [10:0]  mx;
        logic [703:0] sh;
        for (int t = 0; t < cycles; t++) begin
            @(negedge clk);
            r64_out_ready = ($urandom_range(0, 3) != 0);
            r64_in_valid  = 1'b1;
            for (int j = 0; j < 64; j++)
                v[j*11 +: 11] = 11'($urandom_range(0, (t % 4 == 0) ? 7 : 2047));
            r64_in_exp = v;
            #1;
            if (r64_out_ready) checkOutput("r64_in_ready", 704'(r64_in_ready), 704'(1));
            if (t > 10) checkOutput("r64_full", 704'(r64_out_valid), 704'(1));
            if (r64_in_valid && r64_in_ready) q.push_back(r64_in_exp);
            if (r64_out_valid && r64_out_ready) begin
                if (q.size() == 0) begin
                    checkOutput("r64_extra", 704'(1), 704'(0));
                end else begin
                    modelBeat(q.pop_front(), 64, mx, sh);
                    checkOutput("r64_max", 704'(r64_out_exp_max), 704'(mx));
                    checkOutput("r64_shift", r64_out_shift, sh);
                end
            end
        end
        @(negedge clk);
        r64_in_valid = 1'b0;
    endtask

    // Safety net in case any bounded loop is broken by a design fault.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence.
    initial begin
        logic [175:0] v, e_sh, sq[$];
        logic [63:0]  e_sh4;
        logic [10:0]  mx, held_max;
        logic [703:0] sh;
        logic [175:0] held_sh;
        int sent, got, t, stale;

        vec_count     = 0;
        miss_count    = 0;
        rst_n         = 1'b0;
        in_valid      = 1'b1;
        in_exp        = makeBeat(3);
        out_ready     = 1'b0;
        r2_in_valid   = 1'b0;
        r2_in_exp     = '0;
        r2_out_ready  = 1'b1;
        r64_in_valid  = 1'b0;
        r64_in_exp    = '0;
        r64_out_ready = 1'b1;

        // Reset with a beat offered: ready stays high, outputs cleared.
        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready", 704'(d16_in_ready), 704'(1));
        checkOutput("rst_out_valid", 704'(d16_out_valid), 704'(0));
        checkOutput("rst_max", 704'(d16_out_exp_max), 704'(0));
        checkOutput("rst_shift", 704'(d16_out_shift), 704'(0));
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (d16_out_valid) stale++;
        end
        checkOutput("rst_no_capture", 704'(stale), 704'(0));

        // All lanes 0x3FF: max 0x3FF, every shift 0.
        for (int j = 0; j < 16; j++) v[j*11 +: 11] = 11'h3FF;
        applyStimulus("all3ff", v, 11'h3FF, '0, '0);

        // Lane i = i: max 15, shift_i = 15 - i (fits in 4 bits too).
        for (int j = 0; j < 16; j++) begin
            v[j*11 +: 11]   = 11'(j);
            e_sh[j*11 +: 11] = 11'(15 - j);
            e_sh4[j*4 +: 4]  = 4'(15 - j);
        end
        applyStimulus("ramp", v, 11'd15, e_sh, e_sh4);

        // Lane 7 = 0x7FF: full shifts 0x7FF, 4-bit shifts 0xF either way.
        for (int j = 0; j < 16; j++) begin
            v[j*11 +: 11]    = (j == 7) ? 11'h7FF : 11'h000;
            e_sh[j*11 +: 11] = (j == 7) ? 11'h000 : 11'h7FF;
            e_sh4[j*4 +: 4]  = (j == 7) ? 4'h0 : 4'hF;
        end
        applyStimulus("big7", v, 11'h7FF, e_sh, e_sh4);

        // Lane 7 = 0x010: 4-bit shift saturates to 0xF or truncates to 0x0.
        for (int j = 0; j < 16; j++) begin
            v[j*11 +: 11]    = (j == 7) ? 11'h010 : 11'h000;
            e_sh[j*11 +: 11] = (j == 7) ? 11'h000 : 11'h010;
`ifdef EXP_COMPARE_PIPE_SAT_EN
            e_sh4[j*4 +: 4]  = (j == 7) ? 4'h0 : 4'hF;
`else
            e_sh4[j*4 +: 4]  = 4'h0;
`endif
        end
        applyStimulus("small7", v, 11'h010, e_sh, e_sh4);

        // 20 back-to-back beats with out_ready low on cycles 6..9.
        sent = 0;
        got  = 0;
        t    = 0;
        held_max = '0;
        held_sh  = '0;
        while (got < 20 && t < 80) begin
            @(negedge clk);
            t++;
            out_ready = !(t >= 6 && t <= 9);
            in_valid  = (sent < 20);
            in_exp    = makeBeat(sent);
            #1;
            if (t >= 6 && t <= 9) begin
                checkOutput("stall_in_ready", 704'(d16_in_ready), 704'(0));
                checkOutput("stall_out_valid", 704'(d16_out_valid), 704'(1));
            end
            if (t == 6) begin
                held_max = d16_out_exp_max;
                held_sh  = d16_out_shift;
            end
            if (t > 6 && t <= 9) begin
                checkOutput("stall_hold_max", 704'(d16_out_exp_max), 704'(held_max));
                checkOutput("stall_hold_shift", 704'(d16_out_shift), 704'(held_sh));
            end
            if (in_valid && d16_in_ready) begin
                sq.push_back(in_exp);
                sent++;
            end
            if (d16_out_valid && out_ready) begin
                if (sq.size() == 0) begin
                    checkOutput("stream_extra", 704'(1), 704'(0));
                end else begin
                    modelBeat(704'(sq.pop_front()), 16, mx, sh);
                    checkOutput("stream_max", 704'(d16_out_exp_max), 704'(mx));
                    checkOutput("stream_shift", 704'(d16_out_shift), sh);
                end
                got++;
            end
        end
        checkOutput("stream_count", 704'(got), 704'(20));
        in_valid  = 1'b0;
        out_ready = 1'b1;

        // Reset while three beats are in flight: nothing stale may emerge.
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_exp   = makeBeat(40 + b);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("flight_out_valid", 704'(d16_out_valid), 704'(0));
        checkOutput("flight_max", 704'(d16_out_exp_max), 704'(0));
        checkOutput("flight_shift", 704'(d16_out_shift), 704'(0));
        stale = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (d16_out_valid) stale++;
        end
        checkOutput("flight_no_stale", 704'(stale), 704'(0));

        // Random traffic on the 2-lane and 64-lane instances in parallel.
        fork
            runRandom2(400);
            runRandom64(400);
        join

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule

// File: doc/exp_compare_pipe.md
EXP_COMPARE_PIPE -- requirements
Module: exp_compare_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 11, exponent width in bits.
REQ-002 SHALL have parameter LANES, default 16, number of exponent lanes; legal values are powers of two from 2 to 64.
REQ-003 SHALL have parameter SHIFT_W, default 11, width of each shift output; legal range is 1 to WIDTH.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1 bit: an input beat is presented.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-008 SHALL have port in_exp, input, LANES*WIDTH bits: lane i occupies bits [i*WIDTH +: WIDTH]; values are unsigned.
REQ-009 SHALL have port out_valid, output, 1 bit: a result is presented.
REQ-010 SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the result.
REQ-011 SHALL have port out_exp_max, output, WIDTH bits: unsigned maximum over all lanes of the beat.
REQ-012 SHALL have port out_shift, output, LANES*SHIFT_W bits: lane i holds (max - exp_i), with the same lane packing as in_exp.

Function
REQ-013 SHALL transfer an input beat when in_valid and in_ready are both 1 in the same cycle; an output beat transfers when out_valid and out_ready are both 1.
REQ-014 SHALL use a balanced binary max tree of L = log2(LANES) register stages, plus 1 register stage for subtraction: latency L+1 cycles from acceptance to out_valid (5 cycles at LANES=16).
REQ-015 SHALL pick the left operand (lower lane index) in each pairwise compare when operands are equal; the resulting max value is unaffected.
REQ-016 SHALL carry the raw lane exponents and a valid bit alongside each tree stage so that the subtract stage uses the exponents of the same beat.
REQ-017 SHALL compute stall = out_valid AND NOT out_ready; while stall=1, every pipeline stage holds its contents and in_ready=0.
REQ-018 SHALL drive in_ready = NOT stall combinationally; bubbles advance whenever stall=0.
REQ-019 SHALL sustain 1 beat/cycle when out_ready is held at 1; beats are never dropped, duplicated or reordered.
REQ-020 SHALL hold out_exp_max and out_shift stable while out_valid=1 and out_ready=0.
REQ-021 SHALL compute each shift as a WIDTH-bit unsigned difference, always >= 0, before the SHIFT_W reduction of REQ-026 or REQ-027.
REQ-022 SHALL have data outputs that are don't-care while out_valid=0, except immediately after reset (REQ-024).

Reset
REQ-023 SHALL, when rst_n=0 at a rising clk edge, clear all stage valid bits, discarding any beats in flight.
REQ-024 SHALL reset out_valid to 0, out_exp_max to 0 and out_shift to 0.
REQ-025 SHALL drive in_ready = 1 during reset; a beat offered while rst_n=0 is not captured.

Configuration
REQ-026 SHALL, with macro EXP_COMPARE_PIPE_SAT_EN defined, saturate each shift to 2^SHIFT_W-1 when the difference exceeds it.
REQ-027 SHALL, without EXP_COMPARE_PIPE_SAT_EN, output the low SHIFT_W bits of each difference; this is identical to REQ-026 when SHIFT_W=WIDTH.

Structure
REQ-028 SHALL take the stage count function (clog2 of LANES) and the lane slice helpers from the shared package exp_pkg, and SHALL define no local copies of them.
REQ-029 SHALL implement the per-level registered pairwise max as sub-module exp_max_stage, parametrised by WIDTH and input count, and instantiated L times through a generate loop.

Verification
REQ-030 The bench SHALL drive all lanes = 0x3FF, with out_ready=1 -> after 5 cycles: out_exp_max=0x3FF, all shifts 0.
REQ-031 The bench SHALL drive lane i = i (LANES=16) -> out_exp_max=15, shift_i = 15-i.
REQ-032 The bench SHALL drive lane 7 = 0x7FF and all other lanes = 0, with SHIFT_W=4 -> shift_0 = 0xF if EXP_COMPARE_PIPE_SAT_EN is defined, else 0xF (low bits of 0x7FF); and with lane 7 = 0x010 -> shift_0 = 0xF saturated vs 0x0 unsaturated.
REQ-033 The bench SHALL stream 20 back-to-back beats while holding out_ready=0 for cycles 6-9 -> in_ready=0 during the stall, outputs held, all 20 results in order, none lost.
REQ-034 The bench SHALL assert rst_n=0 for 1 cycle while 3 beats are in flight -> next cycle out_valid=0, out_exp_max=0, and no stale beat ever appears.
REQ-035 The bench SHALL run random exponents at LANES=2 and LANES=64, against a scoreboard, with random out_ready -> all results match, and throughput is 1 beat/cycle whenever out_ready=1.
